// File: rtl/teclado_matricial_fifo.sv
// -----------------------------------------------------------------------------
// teclado_matricial_fifo
// Matrix keypad scanner with internal debounce and a code FIFO.
// Drives one column at a time, samples the rows once per dwell period,
// debounces a press and its release, and queues one code per accepted press.
// Codes are linear: fila*COLS + columna.
//
// Ports:
//   clk_i              system clock
//   reset_i            asynchronous active-high reset
//   enable_i           scan enable (0 freezes dwell counter, FSM and columns)
//   filas_i            row sense, active high, already synchronised
//   columnas_o         one-hot column drive, active high
//   codigo_o           code at FIFO head (0 when empty)
//   valid_o            FIFO not empty
//   ready_i            consumer accepts codigo_o
//   ocupacion_o        number of stored codes
//   tecla_presionada_o key accepted and not yet released
//   overflow_o         sticky: a code was dropped on a full FIFO
//   clear_i            clears overflow_o
// -----------------------------------------------------------------------------
module teclado_matricial_fifo #(
    parameter  int ROWS       = 4,
    parameter  int COLS       = 4,
    parameter  int SCAN_DIV   = 1000,
    parameter  int DEBOUNCE   = 4,
    parameter  int FIFO_DEPTH = 8,
    localparam int CODE_W     = $clog2(ROWS*COLS)
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          enable_i,
    input  logic [ROWS-1:0]               filas_i,
    output logic [COLS-1:0]               columnas_o,
    output logic [CODE_W-1:0]             codigo_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   ocupacion_o,
    output logic                          tecla_presionada_o,
    output logic                          overflow_o,
    input  logic                          clear_i
);

    localparam int ROW_W  = $clog2(ROWS);
    localparam int COL_W  = $clog2(COLS);
    localparam int DIV_W  = $clog2(SCAN_DIV);
    localparam int DCNT_W = $clog2(DEBOUNCE+1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_REL} state_t;

    state_t             state;
    logic [DIV_W-1:0]   div_cnt;
    logic [COL_W-1:0]   col_idx;
    logic [COL_W-1:0]   col_next;
    logic [ROW_W-1:0]   row_lat;
    logic [DCNT_W-1:0]  deb_cnt;
    logic               sample;
    logic               any_row;
    logic               row_hit;
    logic               deb_done;
    logic               push;
    logic [CODE_W-1:0]  push_code;

    logic [CODE_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;
    logic               full;
    logic               pop;
    logic               wr_en;

    // Lowest-index active row wins when several rows are high.
    function automatic logic [ROW_W-1:0] lowest_row(input logic [ROWS-1:0] f);
        lowest_row = '0;
        for (int i = ROWS-1; i >= 0; i--) begin
            if (f[i]) lowest_row = ROW_W'(i);
        end
    endfunction

    function automatic logic [CODE_W-1:0] make_code(input logic [ROW_W-1:0] r,
                                                    input logic [COL_W-1:0] c);
        make_code = CODE_W'(int'(r) * COLS + int'(c));
    endfunction

    // Rows are only trusted on the last cycle of the dwell period, when the
    // column drive has had time to settle.
    assign sample   = enable_i && (div_cnt == DIV_W'(SCAN_DIV-1));
    assign any_row  = |filas_i;
    assign row_hit  = filas_i[row_lat];
    // deb_cnt holds agreeing samples so far; this sample would be the last one.
    assign deb_done = (deb_cnt == DCNT_W'(DEBOUNCE-1));
    assign col_next = (col_idx == COL_W'(COLS-1)) ? '0 : col_idx + 1'b1;

    always_comb begin
        columnas_o          = '0;
        columnas_o[col_idx] = 1'b1;
    end

    assign tecla_presionada_o = (state == HELD) || (state == DEB_REL);

    // Push strobe is combinational so the code lands in the FIFO on the same
    // edge as the accepting sample; valid_o follows one cycle later.
    always_comb begin
        push      = 1'b0;
        push_code = make_code(row_lat, col_idx);
        if (sample) begin
            case (state)
                SCAN: begin
                    if (any_row && DEBOUNCE == 1) begin
                        push      = 1'b1;
                        push_code = make_code(lowest_row(filas_i), col_idx);
                    end
                end
                DEB_PRESS: push = row_hit && deb_done;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            div_cnt <= '0;
        end else if (enable_i) begin
            div_cnt <= sample ? '0 : div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state   <= SCAN;
            col_idx <= '0;
            row_lat <= '0;
            deb_cnt <= '0;
        end else if (sample) begin
            case (state)
                SCAN: begin
                    if (any_row) begin
                        row_lat <= lowest_row(filas_i);
                        deb_cnt <= DCNT_W'(1);
                        state   <= (DEBOUNCE == 1) ? HELD : DEB_PRESS;
                    end else begin
                        col_idx <= col_next;
                    end
                end
                DEB_PRESS: begin
                    if (row_hit) begin
                        deb_cnt <= deb_cnt + 1'b1;
                        if (deb_done) state <= HELD;
                    end else begin
                        state   <= SCAN;
                        col_idx <= col_next;
                        deb_cnt <= '0;
                    end
                end
                HELD: begin
                    if (!row_hit) begin
                        if (DEBOUNCE == 1) begin
                            state   <= SCAN;
                            col_idx <= col_next;
                            deb_cnt <= '0;
                        end else begin
                            state   <= DEB_REL;
                            deb_cnt <= DCNT_W'(1);
                        end
                    end
                end
                DEB_REL: begin
                    if (!row_hit) begin
                        if (deb_done) begin
                            state   <= SCAN;
                            col_idx <= col_next;
                            deb_cnt <= '0;
                        end else begin
                            deb_cnt <= deb_cnt + 1'b1;
                        end
                    end else begin
                        state   <= HELD;
                        deb_cnt <= '0;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

    // Code FIFO, first-word-fall-through. A push on a full FIFO still
    // succeeds when the head is popped in the same cycle.
    assign full    = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign valid_o = (count != '0);
    assign pop     = valid_o && ready_i;
    assign wr_en   = push && (!full || pop);

    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr] <= push_code;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            // Set has priority over clear so a drop is never lost.
            if (push && full && !pop) overflow_o <= 1'b1;
            else if (clear_i)         overflow_o <= 1'b0;
        end
    end

    assign codigo_o    = valid_o ? mem[rd_ptr] : '0;
    assign ocupacion_o = count;

endmodule

// File: tb/tb_teclado_matricial_fifo.sv
module tb_teclado_matricial_fifo;

    localparam int ROWS = 4;
    localparam int COLS = 4;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic       enable_i = 1'b1;
    logic [3:0] filas_i = '0;
    logic [3:0] columnas_o;
    logic [3:0] codigo_o;
    logic       valid_o;
    logic       ready_i = 1'b0;
    logic [2:0] ocupacion_o;
    logic       tecla_presionada_o;
    logic       overflow_o;
    logic       clear_i = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    teclado_matricial_fifo #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(4), .DEBOUNCE(3), .FIFO_DEPTH(4)
    ) dut (
        .clk_i(clk),
        .reset_i(reset_i),
        .enable_i(enable_i),
        .filas_i(filas_i),
        .columnas_o(columnas_o),
        .codigo_o(codigo_o),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .ocupacion_o(ocupacion_o),
        .tecla_presionada_o(tecla_presionada_o),
        .overflow_o(overflow_o),
        .clear_i(clear_i)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_col(input int c);
        logic [3:0] m;
        int k;
        m = 4'b0001 << c;
        k = 0;
        while (columnas_o !== m && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) check_eq("wait_col_timeout", k, 0);
    endtask

    task automatic press_at(input int r, input int c);
        wait_col(c);
        filas_i    = '0;
        filas_i[r] = 1'b1;
    endtask

    task automatic release_wait();
        int k;
        filas_i = '0;
        k = 0;
        while (tecla_presionada_o !== 1'b0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) check_eq("release_timeout", k, 0);
    endtask

    task automatic press_key(input int r, input int c);
        press_at(r, c);
        repeat (20) @(negedge clk);
        release_wait();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int exp_codes[4];

        // 1: reset values and column scan
        repeat (3) @(negedge clk);
        check_eq("rst_columnas", columnas_o, 4'b0001);
        check_eq("rst_valid", valid_o, 0);
        check_eq("rst_ocup", ocupacion_o, 0);
        check_eq("rst_codigo", codigo_o, 0);
        check_eq("rst_tecla", tecla_presionada_o, 0);
        check_eq("rst_overflow", overflow_o, 0);
        reset_i = 1'b0;
        check_eq("scan_j0", columnas_o, 4'b0001);
        for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            if (j == 3 || j == 4 || j == 8 || j == 12 || j == 16)
                check_eq($sformatf("scan_j%0d", j), columnas_o, 4'b0001 << ((j / 4) % 4));
        end
        check_eq("scan_valid", valid_o, 0);
        check_eq("scan_ocup", ocupacion_o, 0);
        enable_i = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("enable_hold", columnas_o, 4'b0001);
        enable_i = 1'b1;

        // 2: single press of code 9, held long, then a second press
        press_at(2, 1);
        repeat (11) @(negedge clk);
        check_eq("press_before_push_valid", valid_o, 0);
        @(negedge clk);
        check_eq("press_push_valid", valid_o, 1);
        check_eq("press_push_codigo", codigo_o, 9);
        check_eq("press_push_ocup", ocupacion_o, 1);
        check_eq("press_tecla", tecla_presionada_o, 1);
        repeat (200) @(negedge clk);
        check_eq("held_ocup", ocupacion_o, 1);
        check_eq("held_columnas", columnas_o, 4'b0010);
        release_wait();
        press_key(2, 1);
        check_eq("second_ocup", ocupacion_o, 2);
        check_eq("second_head", codigo_o, 9);
        ready_i = 1'b1;
        @(negedge clk);
        check_eq("pop1_codigo", codigo_o, 9);
        check_eq("pop1_ocup", ocupacion_o, 1);
        @(negedge clk);
        check_eq("pop2_valid", valid_o, 0);
        ready_i = 1'b0;

        // 3: bounce - one high sample only
        press_at(0, 1);
        repeat (4) @(negedge clk);
        check_eq("bounce_frozen", columnas_o, 4'b0010);
        filas_i = '0;
        repeat (4) @(negedge clk);
        check_eq("bounce_next_col", columnas_o, 4'b0100);
        check_eq("bounce_tecla", tecla_presionada_o, 0);
        repeat (12) @(negedge clk);
        check_eq("bounce_valid", valid_o, 0);

        // 4: fill past capacity with ready low, then drain
        press_key(0, 0);
        press_key(1, 1);
        press_key(2, 2);
        press_key(3, 3);
        press_key(0, 3);
        check_eq("ovf_ocup", ocupacion_o, 4);
        check_eq("ovf_flag", overflow_o, 1);
        check_eq("ovf_head", codigo_o, 0);
        exp_codes = '{0, 5, 10, 15};
        ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("drain_%0d", i), codigo_o, exp_codes[i]);
            @(negedge clk);
        end
        ready_i = 1'b0;
        check_eq("drain_valid", valid_o, 0);
        check_eq("drain_ovf_sticky", overflow_o, 1);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        check_eq("clear_ovf", overflow_o, 0);

        // 5: push into a full FIFO while the head is popped
        press_key(0, 1);
        press_key(1, 2);
        press_key(2, 3);
        press_key(3, 0);
        check_eq("full_ocup", ocupacion_o, 4);
        press_at(1, 3);
        repeat (11) @(negedge clk);
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        check_eq("fullpop_ocup", ocupacion_o, 4);
        check_eq("fullpop_ovf", overflow_o, 0);
        check_eq("fullpop_head", codigo_o, 6);
        release_wait();
        exp_codes = '{6, 11, 12, 7};
        ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("fullpop_drain_%0d", i), codigo_o, exp_codes[i]);
            @(negedge clk);
        end
        ready_i = 1'b0;
        check_eq("fullpop_empty", valid_o, 0);

        // 6: asynchronous reset during press debounce
        press_key(0, 2);
        check_eq("pre_rst_head", codigo_o, 2);
        press_at(2, 1);
        repeat (6) @(negedge clk);
        #2;
        reset_i = 1'b1;
        #1;
        check_eq("arst_columnas", columnas_o, 4'b0001);
        check_eq("arst_valid", valid_o, 0);
        check_eq("arst_ocup", ocupacion_o, 0);
        check_eq("arst_codigo", codigo_o, 0);
        check_eq("arst_tecla", tecla_presionada_o, 0);
        check_eq("arst_overflow", overflow_o, 0);
        filas_i = '0;
        @(negedge clk);
        reset_i = 1'b0;
        repeat (40) @(negedge clk);
        check_eq("post_rst_valid", valid_o, 0);
        check_eq("post_rst_ocup", ocupacion_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/teclado_matricial_fifo.md
Name: teclado_matricial_fifo

Overview:
Parametrised matrix-keypad scanner: successor to the fixed 4x4 hex keypad interface with its external 2-bit counter and encoder.
- Drives one-hot column strobes and samples row inputs.
- Debounces internally, emits one linear key code per press and buffers codes in a FIFO with a valid/ready handshake.
- Sits between the keypad pins and the consumer logic (display or register path), replacing the external counter, inhibit and data-available glue.

Parameters:
ROWS, 4, number of row inputs (2..8)
COLS, 4, number of column strobes (2..8)
SCAN_DIV, 1000, clock cycles each column is driven (dwell period, >=2)
DEBOUNCE, 4, consecutive agreeing dwell-period samples needed to accept a press or a release (>=1)
FIFO_DEPTH, 8, code buffer entries (power of 2, >=2)
CODE_W, $clog2(ROWS*COLS), derived code width (localparam)

Ports:
clk_i  in  1  system clock
reset_i  in  1  reset
enable_i  in  1  scan enable; 0 freezes dwell counter and FSM
filas_i  in  ROWS  row sense, active high, already synchronised
columnas_o  out  COLS  one-hot column drive, active high
codigo_o  out  CODE_W  code at FIFO head, fila*COLS+columna
valid_o  out  1  FIFO not empty
ready_i  in  1  consumer accepts codigo_o
ocupacion_o  out  $clog2(FIFO_DEPTH)+1  entries stored
tecla_presionada_o  out  1  high in DEBOUNCE_REL and HELD states
overflow_o  out  1  sticky: a code was dropped
clear_i  in  1  clears overflow_o

Behaviour:
Interface: one clock clk_i; reset_i is asynchronous and active-high.

Reset (async, immediate):
- columnas_o=1 (column 0); state SCAN; dwell and debounce counters 0.
- FIFO empty: valid_o=0, ocupacion_o=0, codigo_o=0.
- overflow_o=0, tecla_presionada_o=0.

Sampling:
- Dwell counter counts 0..SCAN_DIV-1 while enable_i=1.
- filas_i is sampled only on the cycle the counter equals SCAN_DIV-1 (settled sample).

FSM:
- SCAN: at each sample, if any filas_i bit is high, latch the current column and the lowest-index high row, debounce count=1, go DEBOUNCE_PRESS (column frozen). Otherwise advance the column, wrapping COLS-1 to 0.
- DEBOUNCE_PRESS: at each sample, latched row high increments the count.
  - Count reaching DEBOUNCE pushes the code and goes to HELD. With DEBOUNCE=1, the push happens directly from SCAN.
  - Latched row low returns to SCAN and advances the column.
- HELD: column frozen; no further pushes; other keys are ignored.
  - Latched row low starts the release count, going to DEBOUNCE_REL.
- DEBOUNCE_REL: latched row low increments the release count.
  - DEBOUNCE consecutive lows returns to SCAN and advances the column.
  - Latched row high returns to HELD.
- Latency: push is registered on the sample edge of the DEBOUNCE-th agreeing sample; valid_o rises the next cycle.

FIFO:
- First-word-fall-through: codigo_o is the head whenever valid_o=1.
- Pop when valid_o && ready_i.
- Push while full with a pop in the same cycle: both succeed, no overflow.
- Push while full without a pop: code dropped, overflow_o=1 the next cycle.
- clear_i clears overflow_o; simultaneous set and clear: set wins.
- Read/write pointers wrap modulo FIFO_DEPTH.

enable_i=0:
- Dwell counter, FSM and columnas_o hold.
- FIFO pop still operates.

Test Plan:
(bench: ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE=3, FIFO_DEPTH=4)
1. Release reset, filas_i=0 -> columnas_o 0001 for 4 cycles, then 0010, 0100, 1000, 0001 (period 16); valid_o=0; ocupacion_o=0.
2. Hold filas_i[2]=1 while column 1 is strobed, for 200 cycles, ready_i=0 -> exactly one push of codigo_o=9 (3 samples = 12 cycles after first detection); tecla_presionada_o=1; columnas_o stuck at 0010. Release for >=12 cycles, press again -> ocupacion_o=2, both codes 9.
3. Bounce: row high for one sample, then low -> no push; FSM back to SCAN; next strobe is column 2.
4. With ready_i=0, press keys giving codes 0,5,10,15,3 -> ocupacion_o=4, overflow_o=1, head 0. Then ready_i=1 -> pops 0,5,10,15 in order; valid_o=0. clear_i pulse -> overflow_o=0.
5. FIFO full, ready_i=1 on the push cycle -> ocupacion_o stays 4, overflow_o stays 0, new code lands at the tail.
6. Assert reset_i mid-DEBOUNCE_PRESS, between clock edges -> all outputs take reset values immediately; no push after reset deasserts.
